// File: rtl/rv32m_mul_stage_pkg.sv
// Shared definitions for the RV32M multiply stage: datapath width and function encodings.
package rv32m_mul_stage_pkg;

    localparam int XLEN = 32;

    // Values match funct3[1:0] of the RV32M multiply instructions.
    typedef enum logic [1:0] {
        MUL_FN_MUL    = 2'b00,
        MUL_FN_MULH   = 2'b01,
        MUL_FN_MULHSU = 2'b10,
        MUL_FN_MULHU  = 2'b11
    } mul_fn_e;

endpackage

// File: rtl/MulBT32S.sv
// Combinational signed 32x32 -> 64 multiplier built from radix-4 Booth partial products.
module MulBT32S
    import rv32m_mul_stage_pkg::*;
(
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    output logic [2*XLEN-1:0] res
);

    logic [2*XLEN-1:0] a_ext;
    logic [XLEN:0]     b_ext;

    assign a_ext = {{XLEN{op1[XLEN-1]}}, op1};
    // Implicit zero below bit 0 lets every group read a uniform 3-bit window.
    assign b_ext = {op2, 1'b0};

    always_comb begin
        logic [2*XLEN-1:0] pp;
        logic [2:0]        grp;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        res = '0;
        for (int i = 0; i < XLEN / 2; i++) begin
            grp = b_ext[2*i +: 3];
            case (grp)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            res = res + (pp << (2 * i));
        end
    end

endmodule

// File: rtl/rv32m_mul_stage.sv
// RV32M multiply execute stage: operand register (A), shared Booth multiplier, sign
// correction and result register (B); 1 op/cycle, latency 2, valid/ready on both sides.
module rv32m_mul_stage
    import rv32m_mul_stage_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [1:0]       in_fn,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_res,
    output logic [TAG_W-1:0] out_tag
);

    logic               a_vld, b_vld;
    logic [XLEN-1:0]    a_op1, a_op2;
    mul_fn_e            a_fn;
    logic [TAG_W-1:0]   a_tag, b_tag;
    logic [XLEN-1:0]    b_res;
    logic               a_en, b_en;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    hi, sel_res;

    // A stage advances whenever B can take its content, so bubbles never block intake.
    assign b_en     = ~b_vld | out_ready;
    assign a_en     = ~a_vld | b_en;
    assign in_ready = a_en;

    MulBT32S u_mul (
        .op1 (a_op1),
        .op2 (a_op2),
        .res (prod)
    );

    // Unsigned operands are the signed ones plus 2^32 when bit 31 is set; only the
    // cross terms survive mod 2^32 in the upper half.
    always_comb begin
        hi = prod[2*XLEN-1:XLEN];
        if ((a_fn == MUL_FN_MULHSU || a_fn == MUL_FN_MULHU) && a_op2[XLEN-1])
            hi = hi + a_op1;
        if (a_fn == MUL_FN_MULHU && a_op1[XLEN-1])
            hi = hi + a_op2;
        sel_res = (a_fn == MUL_FN_MUL) ? prod[XLEN-1:0] : hi;
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            a_vld <= 1'b0;
            b_vld <= 1'b0;
            a_op1 <= '0;
            a_op2 <= '0;
            a_fn  <= MUL_FN_MUL;
            a_tag <= '0;
            b_res <= '0;
            b_tag <= '0;
        end else if (flush) begin
            a_vld <= 1'b0;
            b_vld <= 1'b0;
        end else begin
            if (b_en) begin
                b_vld <= a_vld;
                if (a_vld) begin
                    b_res <= sel_res;
                    b_tag <= a_tag;
                end
            end
            if (a_en) begin
                a_vld <= in_valid;
                if (in_valid) begin
                    a_op1 <= in_op1;
                    a_op2 <= in_op2;
                    a_fn  <= mul_fn_e'(in_fn);
                    a_tag <= in_tag;
                end
            end
        end
    end

    assign out_valid = b_vld;
    assign out_res   = b_res;
    assign out_tag   = b_tag;

endmodule

// File: tb/tb_rv32m_mul_stage.sv
// Self-checking bench for rv32m_mul_stage: directed vectors plus a cycle-level queue model
// of the in-flight ops, with results computed from 64-bit integer arithmetic.
module tb_rv32m_mul_stage;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_op1 = '0;
    logic [31:0]      in_op2 = '0;
    logic [1:0]       in_fn = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_res;
    logic [TAG_W-1:0] out_tag;

    int n_vec  = 0;
    int n_fail = 0;

    rv32m_mul_stage #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .in_fn     (in_fn),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result from the ISA definition: extend each operand as signed or unsigned to 64 bits.
    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] fn);
        logic [63:0] sa, ua, sb, ub, p;
        sa = {{32{a[31]}}, a};
        ua = {32'b0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (fn)
            2'b00:   p = sa * sb;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (fn == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               acc_edge;
    } exp_t;

    exp_t exp_q[$];
    int   deliv_edges[$];
    int   edge_i = 0;

    // Model: each accepted op becomes visible two edges after acceptance and leaves in
    // order when taken; the stage holds at most two ops.
    always begin
        logic exp_valid, exp_ready;
        int   k;
        @(negedge clk);
        #4;
        k = edge_i + 1;
        if (rst) begin
            exp_q.delete();
        end else begin
            exp_valid = (exp_q.size() > 0) && (k >= exp_q[0].acc_edge + 2);
            exp_ready = !(exp_q.size() == 2 && !out_ready);
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
            if (exp_valid && out_valid) begin
                check("out_res", out_res, exp_q[0].res);
                check("out_tag", {27'b0, out_tag}, {27'b0, exp_q[0].tag});
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_valid && out_ready) begin
                    void'(exp_q.pop_front());
                    deliv_edges.push_back(k);
                end
                if (in_valid && exp_ready)
                    exp_q.push_back('{res: ref_res(in_op1, in_op2, in_fn), tag: in_tag, acc_edge: k});
            end
        end
        edge_i++;
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fn,
                         input logic [TAG_W-1:0] tag);
        in_op1   = a;
        in_op2   = b;
        in_fn    = fn;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    // Present one op at the next negedge, return at the negedge following its accept edge.
    task automatic issue_one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fn,
                             input logic [TAG_W-1:0] tag);
        logic got = 1'b0;
        @(negedge clk);
        drive(a, b, fn, tag);
        for (int t = 0; t < 20; t++) begin
            #4;
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", {31'b0, got}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fn_test(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] fn, input logic [TAG_W-1:0] tag,
                           input logic [31:0] exp);
        out_ready = 1'b1;
        issue_one(a, b, fn, tag);
        check({name, "_lat1_valid"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check({name, "_lat2_valid"}, {31'b0, out_valid}, 32'd1);
        check({name, "_res"}, out_res, exp);
        check({name, "_tag"}, {27'b0, out_tag}, {27'b0, tag});
        @(negedge clk);
        check({name, "_done"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] held_res;
        logic [TAG_W-1:0] held_tag;

        // Reset held for two edges with a beat offered.
        rst = 1'b1;
        in_valid = 1'b1;
        in_op1 = 32'h1234_5678;
        in_op2 = 32'h9abc_def0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_res", out_res, 32'd0);
        check("rst_out_tag", {27'b0, out_tag}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        fn_test("mul",    32'hFFFF_FFFF, 32'h0000_0002, 2'b00, 5'd1, 32'hFFFF_FFFE);
        fn_test("mulh",   32'h8000_0000, 32'h8000_0000, 2'b01, 5'd2, 32'h4000_0000);
        fn_test("mulhsu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 5'd3, 32'hFFFF_FFFF);
        fn_test("mulhu",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd4, 32'hFFFF_FFFE);
        fn_test("mulhsu_pos", 32'h0000_0003, 32'h8000_0000, 2'b10, 5'd5, 32'h0000_0001);

        // Streaming: eight back-to-back ops must come out on eight consecutive edges.
        out_ready = 1'b1;
        base = deliv_edges.size();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(32'h1000_0001 * (i + 1), 32'hF0F0_0000 + i, 2'(i), 5'(i));
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("stream_count", deliv_edges.size() - base, 32'd8);
        if (deliv_edges.size() - base == 8)
            check("stream_span", deliv_edges[base+7] - deliv_edges[base], 32'd7);

        // Backpressure: three ops into a stalled stage.
        base = deliv_edges.size();
        @(negedge clk);
        out_ready = 1'b0;
        drive(32'd7, 32'd6, 2'b00, 5'd10);
        @(negedge clk);
        drive(32'd9, 32'd9, 2'b00, 5'd11);
        @(negedge clk);
        drive(32'hFFFF_FFFF, 32'd5, 2'b11, 5'd12);
        #4;
        check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        held_res = out_res;
        held_tag = out_tag;
        check("bp_first_res", held_res, 32'd42);
        check("bp_first_tag", {27'b0, held_tag}, 32'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_res", out_res, held_res);
            check("bp_hold_tag", {27'b0, out_tag}, {27'b0, held_tag});
        end
        @(negedge clk);
        out_ready = 1'b1;
        #4;
        check("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_delivered", deliv_edges.size() - base, 32'd3);

        // Flush kills the op in A and the beat offered alongside the flush.
        base = deliv_edges.size();
        out_ready = 1'b1;
        @(negedge clk);
        drive(32'd100, 32'd3, 2'b00, 5'd20);
        @(negedge clk);
        flush = 1'b1;
        drive(32'd200, 32'd3, 2'b00, 5'd21);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush_no_valid", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end
        check("flush_none_out", deliv_edges.size() - base, 32'd0);
        fn_test("post_flush", 32'h0001_0000, 32'h0001_0000, 2'b01, 5'd22, 32'h0000_0001);

        // Random traffic with random backpressure; the model checks every cycle.
        begin
            int issued = 0;
            int cycles = 0;
            while (issued < 10000 && cycles < 60000) begin
                @(negedge clk);
                in_valid  = ($urandom_range(3) != 0);
                in_op1    = $urandom();
                in_op2    = $urandom();
                in_fn     = 2'($urandom_range(3));
                in_tag    = 5'($urandom_range(31));
                out_ready = ($urandom_range(3) != 0);
                #4;
                if (in_valid && in_ready)
                    issued++;
                cycles++;
            end
            check("rand_issued", issued, 32'd10000);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("drain_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
